// File: rtl/uart_tx_arbiter_if.sv
// Request, status and byte-transmitter handshake bundle for uart_tx_arbiter.
// slave is the arbiter side; master is the requester/transmitter side.
interface uart_tx_arbiter_if;
    logic        req0;
    logic [63:0] data0;
    logic [3:0]  len0;
    logic        req1;
    logic [63:0] data1;
    logic [3:0]  len1;
    logic        busy0;
    logic        busy1;
    logic        drop0;
    logic        drop1;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        active;
    logic        grant;
    logic        frame_done;
    logic        timeout_err;

    modport slave (
        input  req0, data0, len0,
        input  req1, data1, len1,
        input  tx_done,
        output busy0, busy1, drop0, drop1,
        output tx_start, tx_byte,
        output active, grant,
        output frame_done, timeout_err
    );

    modport master (
        output req0, data0, len0,
        output req1, data1, len1,
        output tx_done,
        input  busy0, busy1, drop0, drop1,
        input  tx_start, tx_byte,
        input  active, grant,
        input  frame_done, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter between two
// 64-bit frame sources, each with a one-deep pending slot.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    function automatic logic [3:0] eff_len(input logic [3:0] l);
        return (l == 4'd0 || l > 4'd8) ? 4'd8 : l;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      pend_q, pend_d;
    logic [1:0][63:0] slot_q, slot_d;
    logic [1:0][3:0] slen_q, slen_d;
    logic [63:0]     shreg_q, shreg_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     wd_q, wd_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [1:0]      drop_q, drop_d;
    logic            done_q, done_d;
    logic            tmo_q, tmo_d;

    logic [1:0]       req;
    logic [1:0][63:0] data_in;
    logic [1:0][3:0]  len_in;
    logic [1:0]       take;
    logic             win;

    assign req     = {bus.req1, bus.req0};
    assign data_in = {bus.data1, bus.data0};
    assign len_in  = {bus.len1, bus.len0};

    // On a tie the source that did not own the previous frame wins.
    assign win = (pend_q == 2'b11) ? ~last_q : pend_q[1];

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        slot_d     = slot_q;
        slen_d     = slen_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        grant_d    = grant_q;
        last_d     = last_q;
        drop_d     = 2'b00;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        take       = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    take[win] = 1'b1;
                    shreg_d   = slot_q[win];
                    cnt_d     = slen_q[win];
                    grant_d   = win;
                    state_d   = SEND;
                end
            end
            SEND: begin
                wd_d    = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 16'd1;
                if (bus.tx_done) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        done_d  = 1'b1;
                        last_d  = grant_q;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A slot being consumed this cycle can be refilled without a drop.
        for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
                if (!pend_q[i] || take[i]) begin
                    slot_d[i] = data_in[i];
                    slen_d[i] = eff_len(len_in[i]);
                    pend_d[i] = 1'b1;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end else if (take[i]) begin
                pend_d[i] = 1'b0;
            end
        end

        tx_start_d = (state_d == SEND);
        tx_byte_d  = tx_start_d ? shreg_d[7:0] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 2'b00;
            slot_q     <= '0;
            slen_q     <= '0;
            shreg_q    <= 64'd0;
            cnt_q      <= 4'd0;
            wd_q       <= 16'd0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            drop_q     <= 2'b00;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            slen_q     <= slen_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.drop0       = drop_q[0];
    assign bus.drop1       = drop_q[1];
    assign bus.frame_done  = done_q;
    assign bus.timeout_err = tmo_q;
    assign bus.grant       = grant_q;
    assign bus.active      = (state_q != IDLE);
    assign bus.busy0       = pend_q[0] | (bus.active & ~grant_q);
    assign bus.busy1       = pend_q[1] | (bus.active & grant_q);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (TIMEOUT_CYC=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Answers every tx_start with tx_done 3 cycles later.
    task automatic run_frame(input logic [63:0] d, input int nb,
                             input logic g, input int exp_lat);
        int lat;
        for (int i = 0; i < nb; i++) begin
            lat = 0;
            while (bus.tx_start !== 1'b1 && lat < 40) begin
                step();
                lat++;
            end
            chk("start_seen", 64'(bus.tx_start), 64'd1);
            if (i == 0 && exp_lat >= 0)
                chk("first_lat", 64'(lat), 64'(exp_lat));
            else if (i > 0)
                chk("b2b_lat", 64'(lat), 64'd0);
            chk($sformatf("byte%0d", i), 64'(bus.tx_byte), 64'(d[8*i +: 8]));
            chk("grant", 64'(bus.grant), 64'(g));
            chk("active", 64'(bus.active), 64'd1);
            repeat (3) step();
            bus.tx_done = 1'b1;
            step();
            bus.tx_done = 1'b0;
            chk("frame_done", 64'(bus.frame_done), 64'(i == nb - 1));
        end
        chk("active_end", 64'(bus.active), 64'd0);
    endtask

    initial begin
        int n;
        bus.req0 = 1'b0;
        bus.data0 = 64'd0;
        bus.len0 = 4'd0;
        bus.req1 = 1'b0;
        bus.data1 = 64'd0;
        bus.len1 = 4'd0;
        bus.tx_done = 1'b0;

        // Reset state
        reset_dut();
        chk("rst_outs", 64'({bus.busy0, bus.busy1, bus.drop0, bus.drop1,
            bus.tx_start, bus.tx_byte, bus.active, bus.grant,
            bus.frame_done, bus.timeout_err}), 64'd0);

        // Single 8-byte frame from source 0
        bus.req0 = 1'b1;
        bus.data0 = 64'h0807060504030201;
        bus.len0 = 4'd8;
        step();
        bus.req0 = 1'b0;
        chk("busy0_pend", 64'(bus.busy0), 64'd1);
        chk("active_pend", 64'(bus.active), 64'd0);
        run_frame(64'h0807060504030201, 8, 1'b0, 1);
        chk("grant_after", 64'(bus.grant), 64'd0);
        chk("busy0_after", 64'(bus.busy0), 64'd0);
        step();
        chk("done_width", 64'(bus.frame_done), 64'd0);

        // Tie from reset: source 0 first, then source 1
        reset_dut();
        bus.req0 = 1'b1;
        bus.data0 = 64'hFFFF_FFFF_FFFF_2211;
        bus.len0 = 4'd2;
        bus.req1 = 1'b1;
        bus.data1 = 64'hEEEE_EEEE_EEEE_4433;
        bus.len1 = 4'd2;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("tie_busy", 64'({bus.busy0, bus.busy1}), 64'd3);
        run_frame(64'hFFFF_FFFF_FFFF_2211, 2, 1'b0, 1);
        run_frame(64'hEEEE_EEEE_EEEE_4433, 2, 1'b1, 1);

        // Source 0 alone, so the next tie must go to source 1
        bus.req0 = 1'b1;
        bus.data0 = 64'h0000_0000_0000_00C3;
        bus.len0 = 4'd1;
        step();
        bus.req0 = 1'b0;
        run_frame(64'h0000_0000_0000_00C3, 1, 1'b0, 1);

        bus.req0 = 1'b1;
        bus.data0 = 64'h8877665544332211;
        bus.len0 = 4'hF;
        bus.req1 = 1'b1;
        bus.data1 = 64'h1234_5678_9ABC_DE5A;
        bus.len1 = 4'd1;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        run_frame(64'h1234_5678_9ABC_DE5A, 1, 1'b1, 1);
        run_frame(64'h8877665544332211, 8, 1'b0, 1);

        // len=0 means 8 bytes; len=3 sends only the low three
        bus.req1 = 1'b1;
        bus.data1 = 64'h1122334455667788;
        bus.len1 = 4'd0;
        step();
        bus.req1 = 1'b0;
        run_frame(64'h1122334455667788, 8, 1'b1, 1);

        bus.req1 = 1'b1;
        bus.data1 = 64'hDEAD_0000_00AA_BBCC;
        bus.len1 = 4'd3;
        step();
        bus.req1 = 1'b0;
        run_frame(64'hDEAD_0000_00AA_BBCC, 3, 1'b1, 1);

        // Second req1 while the slot is full is dropped
        bus.req0 = 1'b1;
        bus.data0 = 64'h0000_0000_0000_005A;
        bus.len0 = 4'd1;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.data1 = 64'h0000_0000_0000_B2B1;
        bus.len1 = 4'd2;
        step();
        chk("drop_start", 64'(bus.tx_start), 64'd1);
        chk("drop_byte", 64'(bus.tx_byte), 64'h5A);
        chk("drop_grant", 64'(bus.grant), 64'd0);
        bus.data1 = 64'hCCCC_CCCC_CCCC_CCCC;
        bus.len1 = 4'd4;
        step();
        bus.req1 = 1'b0;
        chk("drop1", 64'(bus.drop1), 64'd1);
        chk("drop0", 64'(bus.drop0), 64'd0);
        chk("drop_busy1", 64'(bus.busy1), 64'd1);
        step();
        chk("drop1_width", 64'(bus.drop1), 64'd0);
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("drop_fdone", 64'(bus.frame_done), 64'd1);
        run_frame(64'h0000_0000_0000_B2B1, 2, 1'b1, 1);

        // Withheld tx_done: timeout 16 cycles after WAIT entry
        bus.req0 = 1'b1;
        bus.data0 = 64'h0000_0000_0000_6677;
        bus.len0 = 4'd2;
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.data1 = 64'h0000_0000_0000_9988;
        bus.len1 = 4'd2;
        step();
        bus.req1 = 1'b0;
        chk("tmo_start", 64'(bus.tx_start), 64'd1);
        chk("tmo_byte", 64'(bus.tx_byte), 64'h77);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.timeout_err === 1'b1 || bus.active !== 1'b1) n++;
        end
        chk("tmo_early", 64'(n), 64'd0);
        step();
        chk("tmo_pulse", 64'(bus.timeout_err), 64'd1);
        chk("tmo_idle", 64'(bus.active), 64'd0);
        chk("tmo_fdone", 64'(bus.frame_done), 64'd0);
        run_frame(64'h0000_0000_0000_9988, 2, 1'b1, 1);

        // Asynchronous reset mid-frame
        bus.req0 = 1'b1;
        bus.data0 = 64'h0807060504030201;
        bus.len0 = 4'd8;
        step();
        bus.req0 = 1'b0;
        step();
        chk("mid_start", 64'(bus.tx_start), 64'd1);
        step();
        bus.req1 = 1'b1;
        bus.data1 = 64'h0000_0000_0000_00E1;
        bus.len1 = 4'd1;
        step();
        bus.req1 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", 64'({bus.busy0, bus.busy1, bus.drop0, bus.drop1,
            bus.tx_start, bus.tx_byte, bus.active, bus.grant,
            bus.frame_done, bus.timeout_err}), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx_start !== 1'b0 || bus.active !== 1'b0) n++;
        end
        chk("post_rst_quiet", 64'(n), 64'd0);
        bus.req1 = 1'b1;
        bus.data1 = 64'h0000_0000_0000_004D;
        bus.len1 = 4'd1;
        step();
        bus.req1 = 1'b0;
        run_frame(64'h0000_0000_0000_004D, 1, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
